rdcntrl_gen: RTL

Parametrised next-generation SCA readout controller. Tags each completed SCA sample block as matched (LCT+L1A), no-match (LCT only) or unused. Queues matched-block descriptors (block address, L1A position map, L1A number, phase, second-block flag) in a DEPTH-entry FIFO. Presents them to the digitisation sequencer over a valid/ready handshake, returns no-match blocks to the free pool, and counts descriptors dropped on overflow.

---
 rtl/rdcntrl_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rdcntrl_gen.sv
// rdcntrl_gen: SCA readout controller; tags blocks, queues matched descriptors
// Ports: CLK/RST(async hi); tag in: ENBL50 BLK_END BLKIN MATCH NO_MATCH GMATCH L1A;
//   rd out: RD_VLD/RD_RDY RD_BLK RD_L1POS RD_L1AN RD_PHASE RD_SCND;
//   free out: FREE_VLD FREE_BLK; status: FULL EMPTY OVF_CNT.
//   Macro RDC_ALIGN_DLY_EN adds DLY[3:0] input delay on MATCH/NO_MATCH/GMATCH.
module rdcntrl_gen #(
  parameter int NBLK_W = 4,
  parameter int NPOS   = 8,
  parameter int DEPTH  = 4,
  parameter int L1AN_W = 6,
  parameter int OVF_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENBL50,
  input  logic              BLK_END,
  input  logic [NBLK_W-1:0] BLKIN,
  input  logic              MATCH,
  input  logic              NO_MATCH,
  input  logic              GMATCH,
  input  logic              L1A,
`ifdef RDC_ALIGN_DLY_EN
  input  logic [3:0]        DLY,
`endif
  input  logic              RD_RDY,
  output logic              RD_VLD,
  output logic [NBLK_W-1:0] RD_BLK,
  output logic [NPOS-1:0]   RD_L1POS,
  output logic [L1AN_W-1:0] RD_L1AN,
  output logic              RD_PHASE,
  output logic              RD_SCND,
  output logic              FREE_VLD,
  output logic [NBLK_W-1:0] FREE_BLK,
  output logic              FULL,
  output logic              EMPTY,
  output logic [OVF_W-1:0]  OVF_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = NBLK_W + NPOS + L1AN_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic match_d, nomatch_d, gmatch_d;

`ifdef RDC_ALIGN_DLY_EN
  // Plain shift lines, no reset, tap DLY gives DLY+1 cycles.
  logic [15:0] srl_m, srl_nm, srl_gm;

  always_ff @(posedge CLK) begin
    srl_m  <= {srl_m[14:0], MATCH};
    srl_nm <= {srl_nm[14:0], NO_MATCH};
    srl_gm <= {srl_gm[14:0], GMATCH};
  end

  assign match_d   = srl_m[DLY];
  assign nomatch_d = srl_nm[DLY];
  assign gmatch_d  = srl_gm[DLY];
`else
  assign match_d   = MATCH;
  assign nomatch_d = NO_MATCH;
  assign gmatch_d  = GMATCH;
`endif

  logic              f1, l1, f2, g, got;
  logic [NPOS-1:0]   map;
  logic [L1AN_W-1:0] l1a_cnt, l1an_lat;
  logic              phase_lat;
  logic [1:0]        state;
  logic [AW:0]       wptr, rptr;
  logic [DW-1:0]     mem [DEPTH];

  logic              f1_eff, l1_eff, first_g;
  logic [L1AN_W-1:0] cnt_post, l1an_eff;
  logic              phase_eff;
  logic [NPOS-1:0]   map_eff;
  logic              push, pop, drop, wr, rel;
  logic [AW:0]       wptr_n, rptr_n;
  logic [DW-1:0]     desc;

  assign f1_eff    = f1 | match_d;
  assign l1_eff    = l1 | nomatch_d;
  assign cnt_post  = L1A ? l1a_cnt + L1AN_W'(1) : l1a_cnt;
  assign first_g   = gmatch_d & ~got;
  assign l1an_eff  = first_g ? cnt_post : l1an_lat;
  assign phase_eff = first_g ? ENBL50 : phase_lat;
  assign map_eff   = ENBL50 ? {g | gmatch_d, map[NPOS-1:1]} : map;

  assign push = BLK_END & f1_eff;
  assign pop  = (state == S_LOAD);
  // A full FIFO still takes the push if the head leaves this cycle.
  assign drop = push & FULL & ~pop;
  assign wr   = push & ~drop;
  assign rel  = BLK_END & ((l1_eff & ~f1_eff) | drop);

  assign wptr_n = wptr + (AW+1)'(wr);
  assign rptr_n = rptr + (AW+1)'(pop);
  assign desc   = {BLKIN, map_eff, l1an_eff, phase_eff, f2};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f1        <= 1'b0;
      l1        <= 1'b0;
      f2        <= 1'b0;
      g         <= 1'b0;
      got       <= 1'b0;
      map       <= '0;
      l1a_cnt   <= '0;
      l1an_lat  <= '0;
      phase_lat <= 1'b0;
    end else begin
      f1  <= match_d | (f1 & ~BLK_END);
      l1  <= nomatch_d | (l1 & ~BLK_END);
      g   <= gmatch_d | (g & ~ENBL50);
      got <= BLK_END ? 1'b0 : (got | gmatch_d);
      if (BLK_END) f2 <= f1_eff;
      if (BLK_END) map <= '0;
      else if (ENBL50) map <= map_eff;
      if (L1A) l1a_cnt <= cnt_post;
      if (first_g) begin
        l1an_lat  <= cnt_post;
        phase_lat <= ENBL50;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[AW-1:0]] <= desc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      OVF_CNT  <= '0;
      FREE_VLD <= 1'b0;
      FREE_BLK <= '0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      EMPTY    <= (wptr_n == rptr_n);
      FULL     <= (wptr_n[AW] != rptr_n[AW]) &&
                  (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      FREE_VLD <= rel;
      if (rel) FREE_BLK <= BLKIN;
      if (drop && (OVF_CNT != '1)) OVF_CNT <= OVF_CNT + OVF_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      RD_BLK   <= '0;
      RD_L1POS <= '0;
      RD_L1AN  <= '0;
      RD_PHASE <= 1'b0;
      RD_SCND  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:  if (!EMPTY) state <= S_LOAD;
        S_LOAD:  state <= S_VALID;
        S_VALID: if (RD_RDY) state <= EMPTY ? S_IDLE : S_LOAD;
        default: state <= S_IDLE;
      endcase
      if (pop)
        {RD_BLK, RD_L1POS, RD_L1AN, RD_PHASE, RD_SCND} <= mem[rptr[AW-1:0]];
    end
  end

  assign RD_VLD = (state == S_VALID);

endmodule
